// File: rtl/gpu_pkg.sv
// Shared types and constants for the data-memory controller: channel FSM
// state encoding and consumer index sizing.
package gpu_pkg;

   localparam int DEFAULT_NUM_CONSUMERS = 8;
   localparam int CONSUMER_IDX_BITS     = $clog2(DEFAULT_NUM_CONSUMERS);

   typedef enum logic [2:0] {
      CH_IDLE           = 3'd0,
      CH_READ_WAITING   = 3'd1,
      CH_WRITE_WAITING  = 3'd2,
      CH_READ_RELAYING  = 3'd3,
      CH_WRITE_RELAYING = 3'd4
   } mem_ch_state_t;

   // Index width for n consumers, never narrower than one bit.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_channel_fsm.sv
// One data-memory channel: issues a granted consumer request to memory and
// relays the response back until the consumer drops its request.
module mem_channel_fsm
   import gpu_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8,
   parameter int IDX_BITS  = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 grant,
   input  logic                 grant_write,
   input  logic [IDX_BITS-1:0]  grant_consumer,
   input  logic [ADDR_BITS-1:0] grant_address,
   input  logic [DATA_BITS-1:0] grant_data,
   input  logic                 consumer_read_valid,
   input  logic                 consumer_write_valid,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   input  logic                 mem_write_ready,
   output mem_ch_state_t        state,
   output logic [IDX_BITS-1:0]  current_consumer,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   output logic                 relay_read_ready,
   output logic                 relay_write_ready,
   output logic [DATA_BITS-1:0] relay_data,
   output logic                 release_claim
);

   mem_ch_state_t        state_next;
   logic [IDX_BITS-1:0]  current_consumer_next;
   logic                 mem_read_valid_next;
   logic [ADDR_BITS-1:0] mem_read_address_next;
   logic                 mem_write_valid_next;
   logic [ADDR_BITS-1:0] mem_write_address_next;
   logic [DATA_BITS-1:0] mem_write_data_next;
   logic                 relay_read_ready_next;
   logic                 relay_write_ready_next;
   logic [DATA_BITS-1:0] relay_data_next;

   // State and registered outputs; reset abandons any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= CH_IDLE;
         current_consumer  <= '0;
         mem_read_valid    <= 1'b0;
         mem_read_address  <= '0;
         mem_write_valid   <= 1'b0;
         mem_write_address <= '0;
         mem_write_data    <= '0;
         relay_read_ready  <= 1'b0;
         relay_write_ready <= 1'b0;
         relay_data        <= '0;
      end else begin
         state             <= state_next;
         current_consumer  <= current_consumer_next;
         mem_read_valid    <= mem_read_valid_next;
         mem_read_address  <= mem_read_address_next;
         mem_write_valid   <= mem_write_valid_next;
         mem_write_address <= mem_write_address_next;
         mem_write_data    <= mem_write_data_next;
         relay_read_ready  <= relay_read_ready_next;
         relay_write_ready <= relay_write_ready_next;
         relay_data        <= relay_data_next;
      end
   end

   // Next-state and next-output logic; release is a same-cycle strobe to the arbiter.
   always_comb begin
      state_next             = state;
      current_consumer_next  = current_consumer;
      mem_read_valid_next    = mem_read_valid;
      mem_read_address_next  = mem_read_address;
      mem_write_valid_next   = mem_write_valid;
      mem_write_address_next = mem_write_address;
      mem_write_data_next    = mem_write_data;
      relay_read_ready_next  = relay_read_ready;
      relay_write_ready_next = relay_write_ready;
      relay_data_next        = relay_data;
      release_claim          = 1'b0;

      case (state)
         CH_IDLE: begin
            if (grant) begin
               current_consumer_next = grant_consumer;
               if (grant_write) begin
                  mem_write_valid_next   = 1'b1;
                  mem_write_address_next = grant_address;
                  mem_write_data_next    = grant_data;
                  state_next             = CH_WRITE_WAITING;
               end else begin
                  mem_read_valid_next   = 1'b1;
                  mem_read_address_next = grant_address;
                  state_next            = CH_READ_WAITING;
               end
            end else begin
               state_next = CH_IDLE;
            end
         end
         CH_READ_WAITING: begin
            if (mem_read_ready) begin
               mem_read_valid_next   = 1'b0;
               relay_data_next       = mem_read_data;
               relay_read_ready_next = 1'b1;
               state_next            = CH_READ_RELAYING;
            end else begin
               state_next = CH_READ_WAITING;
            end
         end
         CH_WRITE_WAITING: begin
            if (mem_write_ready) begin
               mem_write_valid_next   = 1'b0;
               relay_write_ready_next = 1'b1;
               state_next             = CH_WRITE_RELAYING;
            end else begin
               state_next = CH_WRITE_WAITING;
            end
         end
         CH_READ_RELAYING: begin
            if (!consumer_read_valid) begin
               relay_read_ready_next = 1'b0;
               release_claim         = 1'b1;
               state_next            = CH_IDLE;
            end else begin
               state_next = CH_READ_RELAYING;
            end
         end
         CH_WRITE_RELAYING: begin
            if (!consumer_write_valid) begin
               relay_write_ready_next = 1'b0;
               release_claim          = 1'b1;
               state_next             = CH_IDLE;
            end else begin
               state_next = CH_WRITE_RELAYING;
            end
         end
         default: begin
            state_next             = CH_IDLE;
            mem_read_valid_next    = 1'b0;
            mem_write_valid_next   = 1'b0;
            relay_read_ready_next  = 1'b0;
            relay_write_ready_next = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_controller.sv
// Arbitrates per-thread load/store requests onto a set of data-memory channels
// through a shared claim mask, and routes responses back to the owning thread.
module data_mem_controller
   import gpu_pkg::*;
#(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 8,
   parameter int NUM_CHANNELS  = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
   output logic [NUM_CHANNELS-1:0]            mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]            mem_write_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
   output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

   // The package constant covers the default build; other sizes derive their own.
   localparam int IDX_BITS = (NUM_CONSUMERS == DEFAULT_NUM_CONSUMERS) ?
                             CONSUMER_IDX_BITS : idx_bits(NUM_CONSUMERS);

   logic [NUM_CONSUMERS-1:0] claim;
   logic [NUM_CONSUMERS-1:0] claim_next;

   mem_ch_state_t        ch_state          [NUM_CHANNELS];
   logic [IDX_BITS-1:0]  current_consumer  [NUM_CHANNELS];
   logic [IDX_BITS-1:0]  grant_consumer    [NUM_CHANNELS];
   logic [ADDR_BITS-1:0] grant_address     [NUM_CHANNELS];
   logic [DATA_BITS-1:0] grant_data        [NUM_CHANNELS];
   logic [DATA_BITS-1:0] relay_data        [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] grant;
   logic [NUM_CHANNELS-1:0] grant_write;
   logic [NUM_CHANNELS-1:0] cur_read_valid;
   logic [NUM_CHANNELS-1:0] cur_write_valid;
   logic [NUM_CHANNELS-1:0] relay_read_ready;
   logic [NUM_CHANNELS-1:0] relay_write_ready;
   logic [NUM_CHANNELS-1:0] release_claim;

   // Claim mask register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         claim <= '0;
      end else begin
         claim <= claim_next;
      end
   end

   // Priority arbiter: channels resolve in index order, each seeing the claims
   // made by lower channels this cycle; released consumers free up next cycle.
   always_comb begin
      logic [NUM_CONSUMERS-1:0] mask;
      logic [NUM_CONSUMERS-1:0] release_mask;
      logic                     found;
      mask         = claim;
      release_mask = '0;
      grant        = '0;
      grant_write  = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         grant_consumer[ch] = '0;
         grant_address[ch]  = '0;
         grant_data[ch]     = '0;
         found              = 1'b0;
         if (ch_state[ch] == CH_IDLE) begin
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
               if (!found && !mask[i] && (consumer_read_valid[i] || consumer_write_valid[i])) begin
                  found              = 1'b1;
                  grant[ch]          = 1'b1;
                  grant_write[ch]    = ~consumer_read_valid[i];
                  grant_consumer[ch] = IDX_BITS'(i);
                  grant_address[ch]  = consumer_read_valid[i] ?
                                       consumer_read_address[i*ADDR_BITS +: ADDR_BITS] :
                                       consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
                  grant_data[ch]     = consumer_write_data[i*DATA_BITS +: DATA_BITS];
                  mask[i]            = 1'b1;
               end else begin
                  mask[i] = mask[i];
               end
            end
         end else if (release_claim[ch]) begin
            release_mask[current_consumer[ch]] = 1'b1;
         end else begin
            release_mask = release_mask;
         end
      end
      claim_next = mask & ~release_mask;
   end

   genvar g;
   generate
      for (g = 0; g < NUM_CHANNELS; g++) begin : g_channel
         assign cur_read_valid[g]  = consumer_read_valid[current_consumer[g]];
         assign cur_write_valid[g] = consumer_write_valid[current_consumer[g]];

         mem_channel_fsm #(
            .ADDR_BITS (ADDR_BITS),
            .DATA_BITS (DATA_BITS),
            .IDX_BITS  (IDX_BITS)
         ) u_channel (
            .clk                  (clk),
            .reset                (reset),
            .grant                (grant[g]),
            .grant_write          (grant_write[g]),
            .grant_consumer       (grant_consumer[g]),
            .grant_address        (grant_address[g]),
            .grant_data           (grant_data[g]),
            .consumer_read_valid  (cur_read_valid[g]),
            .consumer_write_valid (cur_write_valid[g]),
            .mem_read_ready       (mem_read_ready[g]),
            .mem_read_data        (mem_read_data[g*DATA_BITS +: DATA_BITS]),
            .mem_write_ready      (mem_write_ready[g]),
            .state                (ch_state[g]),
            .current_consumer     (current_consumer[g]),
            .mem_read_valid       (mem_read_valid[g]),
            .mem_read_address     (mem_read_address[g*ADDR_BITS +: ADDR_BITS]),
            .mem_write_valid      (mem_write_valid[g]),
            .mem_write_address    (mem_write_address[g*ADDR_BITS +: ADDR_BITS]),
            .mem_write_data       (mem_write_data[g*DATA_BITS +: DATA_BITS]),
            .relay_read_ready     (relay_read_ready[g]),
            .relay_write_ready    (relay_write_ready[g]),
            .relay_data           (relay_data[g]),
            .release_claim        (release_claim[g])
         );
      end
   endgenerate

   // Response routing: only the channel that owns a consumer drives its ready/data.
   always_comb begin
      consumer_read_ready  = '0;
      consumer_write_ready = '0;
      consumer_read_data   = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (relay_read_ready[ch]) begin
            consumer_read_ready[current_consumer[ch]] = 1'b1;
            consumer_read_data[current_consumer[ch]*DATA_BITS +: DATA_BITS] = relay_data[ch];
         end else begin
            consumer_read_ready = consumer_read_ready;
         end
         if (relay_write_ready[ch]) begin
            consumer_write_ready[current_consumer[ch]] = 1'b1;
         end else begin
            consumer_write_ready = consumer_write_ready;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller with a one-cycle-latency memory model
// on every channel.
module tb_data_mem_controller;

   localparam int AB  = 8;
   localparam int DB  = 8;
   localparam int NC  = 8;
   localparam int NCH = 4;

   logic clk = 1'b0;
   logic reset;
   logic [NC-1:0]     consumer_read_valid;
   logic [NC*AB-1:0]  consumer_read_address;
   logic [NC-1:0]     consumer_read_ready;
   logic [NC*DB-1:0]  consumer_read_data;
   logic [NC-1:0]     consumer_write_valid;
   logic [NC*AB-1:0]  consumer_write_address;
   logic [NC*DB-1:0]  consumer_write_data;
   logic [NC-1:0]     consumer_write_ready;
   logic [NCH-1:0]    mem_read_valid;
   logic [NCH*AB-1:0] mem_read_address;
   logic [NCH-1:0]    mem_read_ready;
   logic [NCH*DB-1:0] mem_read_data;
   logic [NCH-1:0]    mem_write_valid;
   logic [NCH*AB-1:0] mem_write_address;
   logic [NCH*DB-1:0] mem_write_data;
   logic [NCH-1:0]    mem_write_ready;

   logic [NCH-1:0] stall;
   logic [7:0]     wr_addr_seen;
   logic [7:0]     wr_data_seen;
   int n_cmp  = 0;
   int n_fail = 0;

   data_mem_controller #(
      .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)
   ) dut (
      .clk(clk), .reset(reset),
      .consumer_read_valid(consumer_read_valid),
      .consumer_read_address(consumer_read_address),
      .consumer_read_ready(consumer_read_ready),
      .consumer_read_data(consumer_read_data),
      .consumer_write_valid(consumer_write_valid),
      .consumer_write_address(consumer_write_address),
      .consumer_write_data(consumer_write_data),
      .consumer_write_ready(consumer_write_ready),
      .mem_read_valid(mem_read_valid),
      .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready),
      .mem_read_data(mem_read_data),
      .mem_write_valid(mem_write_valid),
      .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data),
      .mem_write_ready(mem_write_ready)
   );

   always #5 clk = ~clk;

   // Memory contents as seen by reads.
   function automatic logic [7:0] mem_value(input logic [7:0] a);
      case (a)
         8'h10:   return 8'hA5;
         8'h11:   return 8'h99;
         8'h12:   return 8'h3E;
         8'h14:   return 8'h6B;
         default: return a ^ 8'hFF;
      endcase
   endfunction

   // Memory responder: ready one cycle after it sees valid, unless stalled.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_read_ready  <= '0;
         mem_write_ready <= '0;
         mem_read_data   <= '0;
         wr_addr_seen    <= 8'h00;
         wr_data_seen    <= 8'h00;
      end else begin
         for (int ch = 0; ch < NCH; ch++) begin
            if (mem_read_valid[ch] && !mem_read_ready[ch] && !stall[ch]) begin
               mem_read_ready[ch] <= 1'b1;
               mem_read_data[ch*DB +: DB] <= mem_value(mem_read_address[ch*AB +: AB]);
            end else begin
               mem_read_ready[ch] <= 1'b0;
            end
            if (mem_write_valid[ch] && !mem_write_ready[ch] && !stall[ch]) begin
               mem_write_ready[ch] <= 1'b1;
               wr_addr_seen <= mem_write_address[ch*AB +: AB];
               wr_data_seen <= mem_write_data[ch*DB +: DB];
            end else begin
               mem_write_ready[ch] <= 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      stall = '0;
      consumer_read_valid = '0;
      consumer_read_address = '0;
      consumer_write_valid = '0;
      consumer_write_address = '0;
      consumer_write_data = '0;
      repeat (2) tick();
      n_cmp++;
      if ({mem_read_valid, mem_write_valid} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mem_valid: got %b expected 00000000", {mem_read_valid, mem_write_valid});
      end
      n_cmp++;
      if ({consumer_read_ready, consumer_write_ready} !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_consumer_ready: got %h expected 0000", {consumer_read_ready, consumer_write_ready});
      end
      n_cmp++;
      if ({mem_read_address, mem_write_address, mem_write_data} !== 96'h0) begin
         n_fail++;
         $display("FAIL reset_mem_buses: got %h expected 0", {mem_read_address, mem_write_address, mem_write_data});
      end
      n_cmp++;
      if (consumer_read_data !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_read_data: got %h expected 0", consumer_read_data);
      end
      #2 reset = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      consumer_read_address[2*AB +: AB] = 8'h10;
      consumer_read_valid[2] = 1'b1;
      tick();
      n_cmp++;
      if ({mem_read_valid, mem_read_address[7:0], consumer_read_ready} !== {4'b0001, 8'h10, 8'h00}) begin
         n_fail++;
         $display("FAIL read_issue: got valid=%b addr=%h ready=%b expected 0001/10/00000000",
                  mem_read_valid, mem_read_address[7:0], consumer_read_ready);
      end
      tick();
      n_cmp++;
      if (consumer_read_ready !== 8'h00) begin
         n_fail++;
         $display("FAIL read_early_ready: got %b expected 00000000", consumer_read_ready);
      end
      tick();
      n_cmp++;
      if ({consumer_read_ready, consumer_read_data[2*DB +: DB], mem_read_valid} !== {8'b00000100, 8'hA5, 4'b0000}) begin
         n_fail++;
         $display("FAIL read_response: got ready=%b data=%h mvalid=%b expected 00000100/a5/0000",
                  consumer_read_ready, consumer_read_data[2*DB +: DB], mem_read_valid);
      end
      consumer_read_valid[2] = 1'b0;
      tick();
      n_cmp++;
      if (consumer_read_ready !== 8'h00) begin
         n_fail++;
         $display("FAIL read_release: got %b expected 00000000", consumer_read_ready);
      end
      tick();
   endtask

   task automatic test_single_write();
      consumer_write_address[7:0] = 8'h20;
      consumer_write_data[7:0] = 8'h3C;
      consumer_write_valid[0] = 1'b1;
      tick();
      n_cmp++;
      if ({mem_write_valid, mem_write_address[7:0], mem_write_data[7:0]} !== {4'b0001, 8'h20, 8'h3C}) begin
         n_fail++;
         $display("FAIL write_issue: got valid=%b addr=%h data=%h expected 0001/20/3c",
                  mem_write_valid, mem_write_address[7:0], mem_write_data[7:0]);
      end
      consumer_write_address[7:0] = 8'h99;
      consumer_write_data[7:0] = 8'hFF;
      tick();
      n_cmp++;
      if ({mem_write_address[7:0], mem_write_data[7:0]} !== {8'h20, 8'h3C}) begin
         n_fail++;
         $display("FAIL write_captured: got addr=%h data=%h expected 20/3c",
                  mem_write_address[7:0], mem_write_data[7:0]);
      end
      tick();
      n_cmp++;
      if ({consumer_write_ready, mem_write_valid, wr_addr_seen, wr_data_seen} !== {8'b00000001, 4'b0000, 8'h20, 8'h3C}) begin
         n_fail++;
         $display("FAIL write_response: got ready=%b mvalid=%b mem[%h]=%h expected 00000001/0000 mem[20]=3c",
                  consumer_write_ready, mem_write_valid, wr_addr_seen, wr_data_seen);
      end
      consumer_write_valid[0] = 1'b0;
      tick();
      n_cmp++;
      if (consumer_write_ready !== 8'h00) begin
         n_fail++;
         $display("FAIL write_release: got %b expected 00000000", consumer_write_ready);
      end
      tick();
   endtask

   task automatic test_read_priority();
      consumer_read_address[1*AB +: AB] = 8'h11;
      consumer_write_address[1*AB +: AB] = 8'h30;
      consumer_write_data[1*DB +: DB] = 8'h77;
      consumer_read_valid[1] = 1'b1;
      consumer_write_valid[1] = 1'b1;
      tick();
      n_cmp++;
      if ({mem_read_valid, mem_write_valid, mem_read_address[7:0]} !== {4'b0001, 4'b0000, 8'h11}) begin
         n_fail++;
         $display("FAIL prio_read_first: got rv=%b wv=%b addr=%h expected 0001/0000/11",
                  mem_read_valid, mem_write_valid, mem_read_address[7:0]);
      end
      repeat (2) tick();
      n_cmp++;
      if ({consumer_read_ready, consumer_read_data[1*DB +: DB]} !== {8'b00000010, 8'h99}) begin
         n_fail++;
         $display("FAIL prio_read_data: got ready=%b data=%h expected 00000010/99",
                  consumer_read_ready, consumer_read_data[1*DB +: DB]);
      end
      consumer_read_valid[1] = 1'b0;
      tick();
      n_cmp++;
      if ({consumer_read_ready, mem_write_valid} !== {8'h00, 4'b0000}) begin
         n_fail++;
         $display("FAIL prio_no_same_cycle_repick: got ready=%b wv=%b expected 00000000/0000",
                  consumer_read_ready, mem_write_valid);
      end
      tick();
      n_cmp++;
      if ({mem_write_valid, mem_write_address[7:0], mem_write_data[7:0]} !== {4'b0001, 8'h30, 8'h77}) begin
         n_fail++;
         $display("FAIL prio_write_after: got wv=%b addr=%h data=%h expected 0001/30/77",
                  mem_write_valid, mem_write_address[7:0], mem_write_data[7:0]);
      end
      repeat (2) tick();
      n_cmp++;
      if (consumer_write_ready !== 8'b00000010) begin
         n_fail++;
         $display("FAIL prio_write_ready: got %b expected 00000010", consumer_write_ready);
      end
      consumer_write_valid[1] = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_stalled_memory();
      int waited;
      stall[0] = 1'b1;
      consumer_read_address[3*AB +: AB] = 8'h12;
      consumer_read_valid[3] = 1'b1;
      tick();
      for (int k = 0; k < 10; k++) begin
         tick();
         n_cmp++;
         if ({mem_read_valid, mem_read_address[7:0], consumer_read_ready} !== {4'b0001, 8'h12, 8'h00}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got valid=%b addr=%h ready=%b expected 0001/12/00000000",
                     k, mem_read_valid, mem_read_address[7:0], consumer_read_ready);
         end
      end
      stall[0] = 1'b0;
      waited = 0;
      while (!consumer_read_ready[3] && waited < 6) begin
         tick();
         waited++;
      end
      n_cmp++;
      if (waited !== 2) begin
         n_fail++;
         $display("FAIL stall_resume_latency: got %0d cycles expected 2", waited);
      end
      n_cmp++;
      if (consumer_read_data[3*DB +: DB] !== 8'h3E) begin
         n_fail++;
         $display("FAIL stall_data: got %h expected 3e", consumer_read_data[3*DB +: DB]);
      end
      consumer_read_valid[3] = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_oversubscription();
      int served_at [NC];
      int ready_cnt [NC];
      logic [NC-1:0] prev_ready;
      int cyc;
      bit dup;
      for (int i = 0; i < NC; i++) begin
         consumer_read_address[i*AB +: AB] = 8'h40 + 8'(i);
         served_at[i] = -1;
         ready_cnt[i] = 0;
      end
      prev_ready = '0;
      dup = 1'b0;
      consumer_read_valid = 8'hFF;
      tick();
      cyc = 1;
      n_cmp++;
      if ({mem_read_valid, mem_read_address} !== {4'b1111, 32'h43424140}) begin
         n_fail++;
         $display("FAIL oversub_first_wave: got valid=%b addr=%h expected 1111/43424140",
                  mem_read_valid, mem_read_address);
      end
      while (cyc < 30 && (consumer_read_valid != 8'h00 || consumer_read_ready != 8'h00)) begin
         for (int i = 0; i < NC; i++) begin
            if (consumer_read_ready[i] && !prev_ready[i]) begin
               ready_cnt[i]++;
            end
            if (consumer_read_valid[i] && consumer_read_ready[i]) begin
               served_at[i] = cyc;
               n_cmp++;
               if (consumer_read_data[i*DB +: DB] !== (8'hBF - 8'(i))) begin
                  n_fail++;
                  $display("FAIL oversub_data[%0d]: got %h expected %h",
                           i, consumer_read_data[i*DB +: DB], 8'hBF - 8'(i));
               end
               consumer_read_valid[i] = 1'b0;
            end
         end
         for (int a = 0; a < NCH; a++) begin
            for (int b = a + 1; b < NCH; b++) begin
               if (mem_read_valid[a] && mem_read_valid[b] &&
                   mem_read_address[a*AB +: AB] == mem_read_address[b*AB +: AB]) begin
                  dup = 1'b1;
               end
            end
         end
         prev_ready = consumer_read_ready;
         tick();
         cyc++;
      end
      n_cmp++;
      if (consumer_read_valid !== 8'h00) begin
         n_fail++;
         $display("FAIL oversub_timeout: still waiting %b expected 00000000", consumer_read_valid);
      end
      for (int i = 0; i < NC; i++) begin
         n_cmp++;
         if (ready_cnt[i] !== 1 || served_at[i] !== ((i < 4) ? 3 : 7)) begin
            n_fail++;
            $display("FAIL oversub_serve[%0d]: got count=%0d cycle=%0d expected 1/%0d",
                     i, ready_cnt[i], served_at[i], (i < 4) ? 3 : 7);
         end
      end
      n_cmp++;
      if (dup !== 1'b0) begin
         n_fail++;
         $display("FAIL oversub_double_claim: got %b expected 0", dup);
      end
      tick();
   endtask

   task automatic test_reset_mid_waiting();
      int waited;
      bit stale_ready;
      stall[0] = 1'b1;
      consumer_read_address[5*AB +: AB] = 8'h13;
      consumer_read_valid[5] = 1'b1;
      repeat (2) tick();
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({mem_read_valid, mem_read_address, consumer_read_ready} !== {4'b0000, 32'h0, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_async_clear: got valid=%b addr=%h ready=%b expected all zero",
                  mem_read_valid, mem_read_address, consumer_read_ready);
      end
      consumer_read_valid[5] = 1'b0;
      stall[0] = 1'b0;
      tick();
      #2 reset = 1'b0;
      tick();
      consumer_read_address[6*AB +: AB] = 8'h14;
      consumer_read_valid[6] = 1'b1;
      waited = 0;
      stale_ready = 1'b0;
      while (!consumer_read_ready[6] && waited < 8) begin
         tick();
         waited++;
         if (consumer_read_ready[5]) stale_ready = 1'b1;
      end
      n_cmp++;
      if ({waited[7:0], consumer_read_data[6*DB +: DB]} !== {8'd3, 8'h6B}) begin
         n_fail++;
         $display("FAIL reset_fresh_read: got latency=%0d data=%h expected 3/6b",
                  waited, consumer_read_data[6*DB +: DB]);
      end
      n_cmp++;
      if (stale_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_abandoned_ready: got %b expected 0", stale_ready);
      end
      consumer_read_valid[6] = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_single_write();
      test_read_priority();
      test_stalled_memory();
      test_oversubscription();
      test_reset_mid_waiting();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
- Sits directly downstream of the compute cores' per-thread load/store ports and arbitrates up to NUM_CONSUMERS thread requests onto NUM_CHANNELS data-memory channels.
- Read and write valid/ready handshakes are relayed in both directions: thread-side requests go to memory, and memory responses come back to the requesting thread.
- Each channel runs an independent FSM.
- A shared claim mask ensures no consumer is served by two channels at once.

Parameters:
ADDR_BITS, 8, data memory address width
DATA_BITS, 8, data memory word width
NUM_CONSUMERS, 8, thread LSU ports (cores x THREADS_PER_BLOCK)
NUM_CHANNELS, 4, concurrent memory channels (1..NUM_CONSUMERS)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
consumer_read_valid  in  NUM_CONSUMERS  per-thread read request
consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed, consumer i at [i*ADDR_BITS +: ADDR_BITS]
consumer_read_ready  out  NUM_CONSUMERS  read data valid, held until request dropped
consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed read data
consumer_write_valid  in  NUM_CONSUMERS  per-thread write request
consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed
consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed
consumer_write_ready  out  NUM_CONSUMERS  write complete, held until request dropped
mem_read_valid  out  NUM_CHANNELS  memory read request
mem_read_address  out  NUM_CHANNELS*ADDR_BITS  packed
mem_read_ready  in  NUM_CHANNELS  memory read accepted, data valid this cycle
mem_read_data  in  NUM_CHANNELS*DATA_BITS  packed
mem_write_valid  out  NUM_CHANNELS  memory write request
mem_write_address  out  NUM_CHANNELS*ADDR_BITS  packed
mem_write_data  out  NUM_CHANNELS*DATA_BITS  packed
mem_write_ready  in  NUM_CHANNELS  memory write accepted

Behaviour:
- Reset (async):
  - All outputs are 0.
  - All channels go to IDLE.
  - The claim mask and the per-channel current_consumer registers are cleared.
  - Reset mid-transaction abandons the transaction; no ready is ever returned for it.
- Channel states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE:
  - The channel scans consumers from index 0 upward.
  - It picks the first consumer that is unclaimed and has read_valid or write_valid set; read is checked before write for the same consumer.
  - On a pick it sets the claim bit, latches current_consumer, and loads mem_*_address from the consumer (plus mem_write_data for writes).
  - It asserts mem_*_valid and goes to *_WAITING.
- Same-cycle arbitration:
  - Channels resolve in index order within one cycle; a lower channel's claim is visible combinationally to higher channels.
  - So in one cycle, channel 0 takes the lowest requester, channel 1 the next, and so on.
- READ_WAITING:
  - Holds mem_read_valid and address stable until mem_read_ready=1.
  - At that edge: mem_read_valid←0, consumer_read_data[c]←mem_read_data, consumer_read_ready[c]←1, state←READ_RELAYING.
- WRITE_WAITING: same as READ_WAITING, using mem_write_*. On mem_write_ready: mem_write_valid←0, consumer_write_ready[c]←1, state←WRITE_RELAYING.
- *_RELAYING:
  - Ready and data are held until consumer_*_valid[c]=0.
  - Then ready←0, the claim bit is cleared, and state←IDLE.
  - The channel may re-arbitrate on the following cycle; there is no same-cycle re-pick.
- Latency:
  - With mem ready asserted the cycle after valid, the consumer sees ready 3 edges after asserting valid.
  - Release takes 1 edge after valid drops.
- Consumer drops valid while in WAITING (protocol violation): the memory transaction still completes. RELAYING then sees valid=0, so ready pulses 1 cycle.
- More requesters than channels: the excess stall with valid held. No request is lost; a higher index waits until a channel frees.
- A consumer is never held by two channels. The ready/data outputs for consumer c are driven only by the channel whose current_consumer==c.
- Write data and address are captured at pick time; later consumer changes are ignored until release.

Decomposition:
- Shared package gpu_pkg holds:
  - the mem_ch_state_t enum (5 states, 3 bits)
  - localparam CONSUMER_IDX_BITS = $clog2(NUM_CONSUMERS)
- Natural sub-module: mem_channel_fsm, one instance per channel.
  - Inputs: granted request, mem ready/data.
  - Outputs: mem signals, relay ready/data, release.
- The claim-mask arbiter and the output muxing stay in the top.

Test Plan:
- Single read: consumer 2 reads addr 0x10, mem returns 0xA5 with ready 1 cycle later → consumer_read_ready[2]=1 and data 0xA5 on edge 3; ready clears 1 edge after valid drops.
- Single write: consumer 0 writes 0x3C to 0x20 → mem_write_valid[0]=1 with addr 0x20, data 0x3C; consumer_write_ready[0] asserts after mem_write_ready.
- Oversubscription: all 8 consumers read at once, NUM_CHANNELS=4 → consumers 0-3 served first, 4-7 after release; all 8 get correct data; no consumer is double-claimed.
- Read priority: consumer 1 asserts read and write simultaneously → read issued first; write issued only after the read is released.
- Stalled memory: mem_read_ready held 0 for 10 cycles → mem_read_valid and address stay stable; consumer ready stays 0 until ready arrives.
- Reset mid-WAITING: assert reset → all outputs 0 immediately (async); after deassert, a fresh request completes normally.
